pong_score_bank: RTL and testbench
==================================

# pong_score_bank

Parametrised multi-player BCD score bank for the Pong datapath. It holds one D-digit decimal counter per player and increments on per-player point pulses from the ball/collision logic. It drives the digit buses consumed by the text/seven-segment renderers, and optionally detects a win and freezes scoring until the next match clear.

## Interface
- P, default 2, number of players (1..8)
- D, default 2, BCD digits per player (1..6)
- WIN_SCORE, default 11, binary win threshold; legal range 1..10^D−1
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clock clk
- inc  in  P  bit i: add one point to player i this cycle (level-sampled, one point per high cycle)
- clr  in  1  synchronous match clear
- digits  out  P*D*4  player i digit j at bits [(i*D+j)*4 +: 4]; digit 0 is least significant
- ovf  out  P  one-cycle pulse: player i wrapped from all-nines to zero
- game_over  out  1  match decided (SCORE_WIN_EN only, else tied 0)
- winner  out  max(1,$clog2(P))  index of winning player, valid while game_over

## Operation
- Reset values: digits all 0, ovf 0, game_over 0, winner 0, FSM in PLAY.
- Each player's counter is a BCD ripple chain:
  - Digit j increments only when inc[i]=1 and digits 0..j−1 are all 9.
  - A digit equal to 9 that increments becomes 0.
  - Digits never hold values 10..15.
- All-nines + inc wraps to all zeros and pulses ovf[i] on that same edge.
- Players are independent. Simultaneous inc on several players all apply in the same cycle.
- clr has priority over inc. It zeros all counters, clears ovf, game_over and winner, and returns the FSM to PLAY.
- FSM (SCORE_WIN_EN):
  - PLAY: inc applied. If any player's next value equals WIN_SCORE, go to OVER, set game_over=1, and set winner to the lowest such index.
  - OVER: inc ignored, counters hold, ovf stays 0. Only clr or reset leave OVER.
- Comparison is done against the BCD encoding of WIN_SCORE, computed at elaboration time. Score equal to WIN_SCORE triggers the win; exceeding it is unreachable in PLAY.

## Timing
- Increment latency is one cycle: inc high before edge k gives the updated digits after edge k.
- game_over and winner update on the same edge as the winning increment, with no extra cycle.
- ovf is registered: high for exactly the cycle following the wrapping edge.
- clr takes effect on the next edge. inc in the same cycle as clr is discarded.
- An asynchronous reset asserted mid-match forces reset values immediately. Operation resumes on the first edge after deassertion.

## Configuration
- SCORE_WIN_EN defined:
  - WIN_SCORE comparison, the PLAY/OVER FSM and the freeze behaviour are built.
  - game_over and winner are live.
- SCORE_WIN_EN undefined:
  - No FSM; counters always count and wrap.
  - game_over and winner are tied to 0.
  - WIN_SCORE is ignored. The port list is unchanged.

## Structure
- Shared package pong_score_pkg:
  - BCD digit typedef (4-bit).
  - BCD_MAX constant (9).
  - Function converting a binary integer to a D-digit packed BCD vector.
  - FSM state typedef {PLAY, OVER}.
- Sub-module bcd_chain_counter: one D-digit BCD counter with en, clr, wrap pulse and a next-value output. It is instantiated P times by a generate loop.
- Top level contains the win compare, the lowest-index priority pick and the FSM.

## Test plan
- Reset, then 10 single inc[0] pulses (P=2, D=2) -> player 0 digits = 1,0; ovf never asserted; player 1 = 0,0.
- Preload player 0 to 99 with SCORE_WIN_EN off, then inc[0] -> digits 0,0; ovf[0] high for exactly one cycle.
- SCORE_WIN_EN on, WIN_SCORE=11, both players at 10, inc=2'b11 in one cycle -> both show 11, game_over=1, winner=0 on that edge.
- In OVER, pulse inc[1] three times -> scores unchanged; clr -> all digits 0, game_over=0, and the next inc[1] gives player 1 = 1.
- clr and inc[0] asserted in the same cycle -> player 0 = 0 after the edge.
- Assert reset asynchronously mid-clock with scores 7 and 9 -> digits 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/pong_score_pkg.sv
// pong_score_pkg
// Shared types, constants and helpers for the Pong score bank:
//   bcd_digit_t  - one 4-bit BCD digit
//   BCD_MAX      - largest legal digit value (9)
//   MAX_DIGITS   - widest counter supported by to_bcd()
//   to_bcd()     - binary integer -> packed BCD, digit 0 in the low nibble
//   score_state_t - PLAY / OVER match state
package pong_score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam int         MAX_DIGITS = 6;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } score_state_t;

    function automatic logic [MAX_DIGITS*4-1:0] to_bcd(input int unsigned value);
        logic [MAX_DIGITS*4-1:0] result;
        int unsigned             rem;
        result = '0;
        rem    = value;
        for (int j = 0; j < MAX_DIGITS; j++) begin
            result[j*4 +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter
// One D-digit BCD ripple counter for a single player.
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high
//   en      in   add one point on this edge
//   clr     in   synchronous clear, wins over en
//   q       out  registered digits, digit 0 in bits [3:0]
//   q_next  out  value the counter will take on the next edge if clr is low
//   wrap    out  registered pulse: counter rolled from all-nines to zero
module bcd_chain_counter
    import pong_score_pkg::*;
#(
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [D*4-1:0] q,
    output logic [D*4-1:0] q_next,
    output logic         wrap
);

    logic [D*4-1:0] cnt_q;
    logic           wrap_q;
    logic           carry;
    logic           all_nines;

    // Carry starts as the enable and ripples upward while digits roll over.
    // Anything at or above 9 rolls to 0 so a corrupted digit self-heals.
    always_comb begin
        q_next = cnt_q;
        carry  = en;
        for (int j = 0; j < D; j++) begin
            if (carry) begin
                if (cnt_q[j*4 +: 4] >= BCD_MAX) begin
                    q_next[j*4 +: 4] = '0;
                end else begin
                    q_next[j*4 +: 4] = cnt_q[j*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        // A carry out of the top digit means every digit was 9.
        all_nines = carry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= q_next;
            wrap_q <= all_nines;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/pong_score_bank.sv
// pong_score_bank
// P independent D-digit BCD score counters with optional win detection.
// Build option: define SCORE_WIN_EN to build the WIN_SCORE compare and the
// PLAY/OVER freeze FSM; otherwise counters free-run and game_over/winner are 0.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   inc[P]     in   one point per high cycle for player i
//   clr        in   synchronous match clear, priority over inc
//   digits     out  player i digit j at [(i*D+j)*4 +: 4]
//   ovf[P]     out  one-cycle wrap pulse per player
//   game_over  out  match decided
//   winner     out  lowest index that reached WIN_SCORE, valid with game_over
//
// state | meaning
// PLAY  | points accepted, watching for WIN_SCORE
// OVER  | match decided, scores frozen until clr or reset
module pong_score_bank
    import pong_score_pkg::*;
#(
    parameter int P         = 2,
    parameter int D         = 2,
    parameter int WIN_SCORE = 11,
    localparam int W        = (P > 1) ? $clog2(P) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [P-1:0]     inc,
    input  logic             clr,
    output logic [P*D*4-1:0] digits,
    output logic [P-1:0]     ovf,
    output logic             game_over,
    output logic [W-1:0]     winner
);

    localparam logic [MAX_DIGITS*4-1:0] WIN_BCD_FULL = to_bcd(WIN_SCORE);
    localparam logic [D*4-1:0]          WIN_BCD      = WIN_BCD_FULL[D*4-1:0];

    logic [P-1:0]     en;
    logic [P*D*4-1:0] next_bus;

    for (genvar i = 0; i < P; i++) begin : g_player
        bcd_chain_counter #(.D(D)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .en     (en[i]),
            .clr    (clr),
            .q      (digits[i*D*4 +: D*4]),
            .q_next (next_bus[i*D*4 +: D*4]),
            .wrap   (ovf[i])
        );
    end

`ifdef SCORE_WIN_EN
    score_state_t state_q, state_d;
    logic [W-1:0] winner_q, winner_d;
    logic         hit_any;
    logic [W-1:0] pick;

    assign en = inc & {P{(state_q == PLAY) && !clr}};

    // Scan downward so the lowest matching index is the one left in pick.
    always_comb begin
        hit_any = 1'b0;
        pick    = '0;
        for (int i = P - 1; i >= 0; i--) begin
            if (next_bus[i*D*4 +: D*4] == WIN_BCD) begin
                hit_any = 1'b1;
                pick    = W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (clr) begin
            state_d  = PLAY;
            winner_d = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (hit_any) begin
                        state_d  = OVER;
                        winner_d = pick;
                    end
                end
                OVER:    state_d = OVER;
                default: state_d = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PLAY;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    assign game_over = (state_q == OVER);
    assign winner    = winner_q;
`else
    logic unused_win;

    assign en        = inc & {P{!clr}};
    assign game_over = 1'b0;
    assign winner    = '0;
    // Next values and the win threshold only matter with win detection built.
    assign unused_win = ^{next_bus, WIN_BCD};
`endif

endmodule

// File: tb/tb_pong_score_bank.sv
module tb_pong_score_bank;

    logic        clk;
    logic        reset;
    logic [1:0]  inc;
    logic        clr;
    logic [15:0] digits;
    logic [1:0]  ovf;
    logic        game_over;
    logic [0:0]  winner;

    int n_checks = 0;
    int n_fail   = 0;

    pong_score_bank #(.P(2), .D(2), .WIN_SCORE(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc),
        .clr       (clr),
        .digits    (digits),
        .ovf       (ovf),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  inc;
        logic        clr;
        logic [15:0] exp_d;
        logic [1:0]  exp_ovf;
        string       name;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [1:0] i, input logic c);
        @(negedge clk);
        inc = i;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // digits layout {p1d1, p1d0, p0d1, p0d0}
        tbl[0] = '{2'b01, 1'b0, 16'h0001, 2'b00, "inc_p0"};
        tbl[1] = '{2'b10, 1'b0, 16'h0101, 2'b00, "inc_p1"};
        tbl[2] = '{2'b11, 1'b0, 16'h0202, 2'b00, "inc_both"};
        tbl[3] = '{2'b00, 1'b0, 16'h0202, 2'b00, "idle_hold"};
        tbl[4] = '{2'b11, 1'b1, 16'h0000, 2'b00, "clr_beats_inc"};
        tbl[5] = '{2'b01, 1'b0, 16'h0001, 2'b00, "after_clr_p0"};
        tbl[6] = '{2'b01, 1'b0, 16'h0002, 2'b00, "p0_2"};
        tbl[7] = '{2'b11, 1'b0, 16'h0103, 2'b00, "both_again"};
        tbl[8] = '{2'b01, 1'b1, 16'h0000, 2'b00, "clr_with_inc0"};
        tbl[9] = '{2'b00, 1'b0, 16'h0000, 2'b00, "idle_zero"};

        reset = 1'b1;
        inc   = 2'b00;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_game_over", 32'(game_over), 32'h0);
        chk("reset_winner", 32'(winner), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            step(tbl[k].inc, tbl[k].clr);
            chk({"tbl_digits_", tbl[k].name}, 32'(digits), 32'(tbl[k].exp_d));
            chk({"tbl_ovf_", tbl[k].name}, 32'(ovf), 32'(tbl[k].exp_ovf));
            chk({"tbl_go_", tbl[k].name}, 32'(game_over), 32'h0);
        end

        // Ten single points on player 0: decade carry into digit 1.
        for (int k = 0; k < 10; k++) begin
            step(2'b01, 1'b0);
            chk("ten_inc_ovf", 32'(ovf), 32'h0);
            step(2'b00, 1'b0);
        end
        chk("ten_inc_digits", 32'(digits), 32'h0010);
        step(2'b00, 1'b1);
        chk("clr_after_ten", 32'(digits), 32'h0);

`ifdef SCORE_WIN_EN
        for (int k = 0; k < 10; k++) step(2'b11, 1'b0);
        chk("both_ten", 32'(digits), 32'h1010);
        chk("both_ten_go", 32'(game_over), 32'h0);
        step(2'b11, 1'b0);
        chk("tie_win_digits", 32'(digits), 32'h1111);
        chk("tie_win_go", 32'(game_over), 32'h1);
        chk("tie_win_winner", 32'(winner), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(2'b10, 1'b0);
            chk("over_frozen", 32'(digits), 32'h1111);
            chk("over_ovf", 32'(ovf), 32'h0);
            chk("over_go_held", 32'(game_over), 32'h1);
            step(2'b00, 1'b0);
        end
        step(2'b00, 1'b1);
        chk("over_clr_digits", 32'(digits), 32'h0);
        chk("over_clr_go", 32'(game_over), 32'h0);
        chk("over_clr_winner", 32'(winner), 32'h0);
        step(2'b10, 1'b0);
        chk("post_clr_p1", 32'(digits), 32'h0100);
        for (int k = 0; k < 10; k++) step(2'b10, 1'b0);
        chk("p1_win_digits", 32'(digits), 32'h1100);
        chk("p1_win_go", 32'(game_over), 32'h1);
        chk("p1_win_winner", 32'(winner), 32'h1);
        step(2'b00, 1'b1);
        chk("p1_win_clr", 32'(game_over), 32'h0);
`else
        for (int k = 0; k < 99; k++) step(2'b01, 1'b0);
        chk("p0_at_99", 32'(digits), 32'h0099);
        chk("p0_at_99_ovf", 32'(ovf), 32'h0);
        step(2'b01, 1'b0);
        chk("wrap_digits", 32'(digits), 32'h0000);
        chk("wrap_ovf_pulse", 32'(ovf), 32'h1);
        step(2'b00, 1'b0);
        chk("wrap_ovf_one_cycle", 32'(ovf), 32'h0);
        chk("wrap_go_tied", 32'(game_over), 32'h0);
        step(2'b00, 1'b1);
`endif

        // Scores 7 and 9, then reset in the middle of the low phase.
        for (int k = 0; k < 7; k++) step(2'b11, 1'b0);
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);
        chk("pre_reset_scores", 32'(digits), 32'h0907);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_digits", 32'(digits), 32'h0);
        chk("async_reset_go", 32'(game_over), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        step(2'b01, 1'b0);
        chk("resume_after_reset", 32'(digits), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
